// File: rtl/button_event.sv
// Button event decoder: turns a debounced button level into press, release,
// long-press and auto-repeat pulses, and keeps a running count of presses.
// Handshake note: there is no valid/ready flow here. `tick` is a one-cycle
// strobe that is sampled on each clk edge, and every event output is a
// registered pulse exactly one clk wide.
// Because `release` is a reserved word in SystemVerilog, the release pulse
// port is named release_pulse. The FSM state and the tick counter are also
// driven out on the debug ports dbg_state and dbg_cnt.
module button_event #(
  parameter int LONG_TICKS   = 50,
  parameter int REPEAT_TICKS = 10
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       tick,
  input  logic       in,
  output logic       press,
  output logic       release_pulse,
  output logic       long_press,
  output logic       rpt,
  output logic       held,
  output logic [7:0] press_count,
  output logic [1:0] dbg_state,
  output logic [7:0] dbg_cnt
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PRESSED = 2'd1,
    LONG    = 2'd2
  } state_t;

  // Terminal counts, held at the same width as the counter.
  localparam logic [7:0] LONG_LAST   = 8'(LONG_TICKS - 1);
  localparam logic [7:0] REPEAT_LAST = 8'(REPEAT_TICKS - 1);

  state_t     state;
  logic       in_q;
  logic       in_q2;
  logic [7:0] cnt;
  logic       rise;
  logic       fall;

  // Edge detection works on the two-stage input history.
  assign rise = in_q & ~in_q2;
  assign fall = ~in_q & in_q2;

  assign dbg_state = state;
  assign dbg_cnt   = cnt;

  // Input history, FSM, tick counter and registered event outputs.
  // Event pulses default to 0 each cycle, so each one lasts a single clk.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state         <= IDLE;
      in_q          <= 1'b0;
      in_q2         <= 1'b0;
      cnt           <= 8'd0;
      press         <= 1'b0;
      release_pulse <= 1'b0;
      long_press    <= 1'b0;
      rpt           <= 1'b0;
      held          <= 1'b0;
      press_count   <= 8'd0;
    end else begin
      in_q          <= in;
      in_q2         <= in_q;
      press         <= 1'b0;
      release_pulse <= 1'b0;
      long_press    <= 1'b0;
      rpt           <= 1'b0;
      case (state)
        IDLE: begin
          // Ticks are ignored while idle, so the counter stays at zero.
          cnt <= 8'd0;
          if (rise) begin
            state       <= PRESSED;
            press       <= 1'b1;
            held        <= 1'b1;
            press_count <= press_count + 8'd1;
          end else begin
            held <= 1'b0;
          end
        end
        PRESSED: begin
          // A release takes priority over a terminal-count tick in the same cycle.
          if (fall) begin
            state         <= IDLE;
            release_pulse <= 1'b1;
            held          <= 1'b0;
            cnt           <= 8'd0;
          end else if (tick) begin
            if (cnt == LONG_LAST) begin
              state      <= LONG;
              long_press <= 1'b1;
              cnt        <= 8'd0;
            end else begin
              cnt <= cnt + 8'd1;
            end
          end
        end
        LONG: begin
          // The FSM stays in LONG and pulses rpt every REPEAT_TICKS ticks.
          if (fall) begin
            state         <= IDLE;
            release_pulse <= 1'b1;
            held          <= 1'b0;
            cnt           <= 8'd0;
          end else if (tick) begin
            if (cnt == REPEAT_LAST) begin
              rpt <= 1'b1;
              cnt <= 8'd0;
            end else begin
              cnt <= cnt + 8'd1;
            end
          end
        end
        default: begin
          // The unused encoding recovers to IDLE.
          state <= IDLE;
          held  <= 1'b0;
          cnt   <= 8'd0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_button_event.sv
// Testbench for button_event with LONG_TICKS=4 and REPEAT_TICKS=2.
module tb_button_event;

  localparam int LT = 4;
  localparam int RT = 2;

  // Clock and reset
  logic       clk = 1'b0;
  logic       reset;
  logic       tick;
  logic       in;
  logic       press;
  logic       release_pulse;
  logic       long_press;
  logic       rpt;
  logic       held;
  logic [7:0] press_count;
  logic [1:0] dbg_state;
  logic [7:0] dbg_cnt;

  always #5 clk = ~clk;

  button_event #(
    .LONG_TICKS  (LT),
    .REPEAT_TICKS(RT)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .tick         (tick),
    .in           (in),
    .press        (press),
    .release_pulse(release_pulse),
    .long_press   (long_press),
    .rpt          (rpt),
    .held         (held),
    .press_count  (press_count),
    .dbg_state    (dbg_state),
    .dbg_cnt      (dbg_cnt)
  );

  // Vector table: inputs for one clk, then the expected outputs after that edge.
  // exp_out = {press, release_pulse, long_press, rpt, held}
  typedef struct {
    logic       iv;
    logic       tv;
    logic [4:0] exp_out;
    logic [7:0] exp_cnt;
  } vec_t;

  localparam int NV = 27;
  vec_t vecs[NV];

  // Scoreboard counters and statistics
  int n_checks = 0;
  int n_fail   = 0;
  int k;
  int n_press, n_rel, n_lp, n_rpt, n_held;
  int press_at, rel_at, lp_at, rpt_first, rpt_last;
  int onehot_err, max_cnt;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic clear_stats();
    k = 0; n_press = 0; n_rel = 0; n_lp = 0; n_rpt = 0; n_held = 0;
    press_at = 0; rel_at = 0; lp_at = 0; rpt_first = 0; rpt_last = 0;
    onehot_err = 0; max_cnt = 0;
  endtask

  // Driver task: apply inputs for one clk and sample on the following negedge.
  task automatic step(input logic iv, input logic tv);
    in   = iv;
    tick = tv;
    @(negedge clk);
    k++;
    if (press) begin n_press++; press_at = k; end
    if (release_pulse) begin n_rel++; rel_at = k; end
    if (long_press) begin n_lp++; lp_at = k; end
    if (rpt) begin
      n_rpt++;
      if (rpt_first == 0) rpt_first = k;
      rpt_last = k;
    end
    if (held) n_held++;
    if (int'(press) + int'(release_pulse) + int'(long_press) + int'(rpt) > 1) onehot_err++;
    if (int'(dbg_cnt) > max_cnt) max_cnt = int'(dbg_cnt);
  endtask

  // Hold the level for n clks, with a tick on every fifth step.
  task automatic run_level(input logic iv, input int n);
    for (int i = 0; i < n; i++) step(iv, ((k + 1) % 5) == 0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    in    = 1'b0;
    tick  = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    clear_stats();
  endtask

  initial begin
    vecs[0]  = '{1'b1, 1'b0, 5'b00000, 8'd0};
    vecs[1]  = '{1'b1, 1'b0, 5'b10001, 8'd0};
    vecs[2]  = '{1'b1, 1'b1, 5'b00001, 8'd1};
    vecs[3]  = '{1'b0, 1'b0, 5'b00001, 8'd1};
    vecs[4]  = '{1'b0, 1'b0, 5'b01000, 8'd0};
    vecs[5]  = '{1'b0, 1'b0, 5'b00000, 8'd0};
    vecs[6]  = '{1'b1, 1'b0, 5'b00000, 8'd0};
    vecs[7]  = '{1'b1, 1'b0, 5'b10001, 8'd0};
    vecs[8]  = '{1'b1, 1'b1, 5'b00001, 8'd1};
    vecs[9]  = '{1'b1, 1'b1, 5'b00001, 8'd2};
    vecs[10] = '{1'b1, 1'b1, 5'b00001, 8'd3};
    vecs[11] = '{1'b0, 1'b0, 5'b00001, 8'd3};
    vecs[12] = '{1'b0, 1'b1, 5'b01000, 8'd0};
    vecs[13] = '{1'b0, 1'b0, 5'b00000, 8'd0};
    vecs[14] = '{1'b1, 1'b0, 5'b00000, 8'd0};
    vecs[15] = '{1'b1, 1'b0, 5'b10001, 8'd0};
    vecs[16] = '{1'b1, 1'b1, 5'b00001, 8'd1};
    vecs[17] = '{1'b1, 1'b1, 5'b00001, 8'd2};
    vecs[18] = '{1'b1, 1'b1, 5'b00001, 8'd3};
    vecs[19] = '{1'b1, 1'b1, 5'b00101, 8'd0};
    vecs[20] = '{1'b1, 1'b1, 5'b00001, 8'd1};
    vecs[21] = '{1'b1, 1'b1, 5'b00011, 8'd0};
    vecs[22] = '{1'b1, 1'b0, 5'b00001, 8'd0};
    vecs[23] = '{1'b0, 1'b1, 5'b00001, 8'd1};
    vecs[24] = '{1'b0, 1'b1, 5'b01000, 8'd0};
    vecs[25] = '{1'b0, 1'b0, 5'b00000, 8'd0};
    vecs[26] = '{1'b0, 1'b1, 5'b00000, 8'd0};

    clear_stats();
    reset = 1'b0;
    in    = 1'b0;
    tick  = 1'b0;

    // Asynchronous reset at power-up, asserted before any clk edge.
    #2 reset = 1'b1;
    #1;
    check("reset_outputs", {press, release_pulse, long_press, rpt, held}, 5'b00000);
    check("reset_count", press_count, 8'd0);
    check("reset_state", dbg_state, 2'd0);
    @(negedge clk);
    reset = 1'b0;

    // Table-driven vectors: short press, fall/tick race in PRESSED,
    // long press with repeat and a fall/tick race in LONG, and an idle tick.
    for (int i = 0; i < NV; i++) begin
      step(vecs[i].iv, vecs[i].tv);
      check($sformatf("vec%0d_out", i), {press, release_pulse, long_press, rpt, held}, vecs[i].exp_out);
      check($sformatf("vec%0d_cnt", i), dbg_cnt, vecs[i].exp_cnt);
    end
    check("vec_press_count", press_count, 8'd3);

    // Short press, 12 clks high, with free-running ticks.
    do_reset();
    run_level(1'b1, 12);
    run_level(1'b0, 6);
    check("short_press_at", press_at, 2);
    check("short_rel_at", rel_at, 14);
    check("short_n_press", n_press, 1);
    check("short_n_rel", n_rel, 1);
    check("short_n_lp", n_lp, 0);
    check("short_count", press_count, 8'd1);

    // Long hold for 40 clks: the ticks arrive at steps 5, 10, 15 and so on.
    do_reset();
    run_level(1'b1, 40);
    run_level(1'b0, 10);
    check("long_press_at", press_at, 2);
    check("long_lp_at", lp_at, 20);
    check("long_n_lp", n_lp, 1);
    check("long_rpt_first", rpt_first, 30);
    check("long_rpt_last", rpt_last, 40);
    check("long_n_rpt", n_rpt, 2);
    check("long_n_held", n_held, 40);
    check("long_rel_at", rel_at, 42);
    check("long_onehot", onehot_err, 0);

    // press_count wraps after 256 short presses.
    do_reset();
    for (int p = 0; p < 255; p++) begin
      run_level(1'b1, 3);
      run_level(1'b0, 3);
    end
    check("wrap_count_255", press_count, 8'd255);
    run_level(1'b1, 3);
    run_level(1'b0, 3);
    check("wrap_count_0", press_count, 8'd0);
    check("wrap_n_press", n_press, 256);
    check("wrap_n_rel", n_rel, 256);
    check("wrap_onehot", onehot_err, 0);

    // Async reset while in LONG, asserted between clk edges.
    do_reset();
    run_level(1'b1, 20);
    check("ar_long_press", long_press, 1'b1);
    check("ar_state_long", dbg_state, 2'd2);
    #2 reset = 1'b1;
    #1;
    check("ar_outputs", {press, release_pulse, long_press, rpt, held}, 5'b00000);
    check("ar_count", press_count, 8'd0);
    check("ar_state", dbg_state, 2'd0);
    @(negedge clk);
    reset = 1'b0;
    clear_stats();
    for (int i = 0; i < 4; i++) step(1'b1, 1'b0);
    check("ar_press_at", press_at, 2);
    check("ar_n_press", n_press, 1);
    check("ar_n_rel", n_rel, 0);
    check("ar_count_after", press_count, 8'd1);

    // Ticks toggling with in low for 100 clks.
    do_reset();
    for (int i = 0; i < 100; i++) step(1'b0, i[0]);
    check("idle_pulses", n_press + n_rel + n_lp + n_rpt, 0);
    check("idle_held", n_held, 0);
    check("idle_max_cnt", max_cnt, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/button_event.md
BUTTON_EVENT -- requirements
Module: button_event

Interface
REQ-001 Parameter LONG_TICKS, default 50: number of tick strobes a press must persist before it counts as a long press; legal range 1..255.
REQ-002 Parameter REPEAT_TICKS, default 10: tick strobes between auto-repeat pulses once long press is reached; legal range 1..255.
REQ-003 Port clk  input  1  single system clock; all state changes on its rising edge.
REQ-004 Port reset  input  1  asynchronous, active-high reset.
REQ-005 Port tick  input  1  slow time-base strobe, one clk cycle wide, synchronous to clk.
REQ-006 Port in  input  1  debounced button level, synchronous to clk; 1 = pressed.
REQ-007 Port press  output  1  one-cycle pulse on press.
REQ-008 Port release  output  1  one-cycle pulse on release.
REQ-009 Port long_press  output  1  one-cycle pulse when a press reaches LONG_TICKS.
REQ-010 Port rpt  output  1  one-cycle auto-repeat pulse while in long-press hold.
REQ-011 Port held  output  1  level; 1 while the FSM is in PRESSED or LONG.
REQ-012 Port press_count  output  8  running count of press pulses.

Function
REQ-013 The block SHALL register in into in_q, and in_q into in_q2, every clk; rise = in_q & ~in_q2, fall = ~in_q & in_q2.
REQ-014 All outputs SHALL be registered; press SHALL assert exactly two clk edges after in first samples high (2-cycle latency), and release likewise after in first samples low.
REQ-015 FSM states SHALL be IDLE, PRESSED and LONG, encoded in 2 bits; the unused encoding SHALL return to IDLE on the next clk.
REQ-016 IDLE: on rise -> PRESSED, pulse press, clear tick counter cnt (8 bits), increment press_count.
REQ-017 PRESSED: cnt increments on each tick; on a tick with cnt == LONG_TICKS-1 -> LONG, pulse long_press, clear cnt.
REQ-018 LONG: cnt increments on each tick; on a tick with cnt == REPEAT_TICKS-1, pulse rpt and clear cnt; the state stays LONG.
REQ-019 In PRESSED or LONG: fall -> IDLE, pulse release, clear cnt.
REQ-020 Fall and a terminal-count tick in the same cycle: fall wins; release pulses; long_press and rpt stay 0.
REQ-021 Rise while not in IDLE cannot occur legally; it SHALL be ignored.
REQ-022 Ticks in IDLE SHALL be ignored; cnt holds 0.
REQ-023 press_count SHALL wrap 255 -> 0 without a flag.
REQ-024 At most one of press, release, long_press and rpt SHALL be high in any cycle.
REQ-025 held SHALL be 1 from the cycle press is high through the cycle before release is high.

Reset
REQ-026 On reset assertion, state, in_q, in_q2, cnt, press_count and all outputs SHALL go to 0/IDLE immediately, without waiting for clk.
REQ-027 Reset mid-press SHALL abort the press with no release pulse.
REQ-028 If in is high through reset deassertion, press SHALL pulse two clk edges after the first post-reset edge, and press_count SHALL become 1.

Verification (bench uses LONG_TICKS=4, REPEAT_TICKS=2, tick every 5 clks)
REQ-029 Short press: in high for 12 clks, then low -> press at edge 2, release 2 edges after the fall; long_press = 0, press_count = 1.
REQ-030 Long hold: in high for 40 clks -> long_press after the 4th tick; rpt after the 6th and 8th ticks; held = 1 throughout; release on the fall.
REQ-031 Race: in falls in the same cycle the 4th tick is seen -> release only; no long_press.
REQ-032 Wrap: 256 short presses -> press_count = 0, with exactly 256 press and 256 release pulses.
REQ-033 Async reset during LONG, asserted between clk edges -> outputs 0 immediately; in still high after deassert -> press 2 edges later, press_count = 1.
REQ-034 Idle ticks: tick toggling with in low for 100 clks -> no output pulses; cnt stays 0.
